// File: rtl/int2flt_seq.sv
`default_nettype none
// ============================================================================
// Module   : int2flt_seq
// Brief    : Sequential 16-bit signed integer to IEEE-754 half-float converter
//            (round-to-nearest-even), acting as data-memory master.
// Revision : 1.0 - initial release
// ============================================================================
module int2flt_seq #(
    parameter logic [7:0] IN_ADDR  = 8'd0,
    parameter logic [7:0] OUT_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD_LO = 4'd1;
    localparam logic [3:0] S_RD_HI = 4'd2;
    localparam logic [3:0] S_PREP  = 4'd3;
    localparam logic [3:0] S_NORM  = 4'd4;
    localparam logic [3:0] S_ROUND = 4'd5;
    localparam logic [3:0] S_WR_LO = 4'd6;
    localparam logic [3:0] S_WR_HI = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [4:0] c_EXP_TOP = 5'd30;

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic        r_start_q;
    logic [15:0] r_x;
    logic        r_sign;
    logic [15:0] r_mag;
    logic [4:0]  r_exp;
    logic [15:0] r_result;

    logic        w_trigger;
    logic        w_round_up;
    logic [14:0] w_rounded;
    logic [7:0]  w_in_addr_hi;
    logic [7:0]  w_out_addr_hi;

    assign w_trigger     = r_start_q & ~start;
    assign w_in_addr_hi  = IN_ADDR + 8'd1;
    assign w_out_addr_hi = OUT_ADDR + 8'd1;

    // Ties go to the even mantissa; a carry out of the mantissa bumps the exponent.
    assign w_round_up = r_mag[4] & ((|r_mag[3:0]) | r_mag[5]);
    assign w_rounded  = {r_exp, r_mag[14:5]} + {14'd0, w_round_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_q <= start;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next_state = S_RD_LO;
            S_RD_LO: w_next_state = S_RD_HI;
            S_RD_HI: w_next_state = S_PREP;
            S_PREP:  w_next_state = (r_x == 16'd0) ? S_WR_LO : S_NORM;
            S_NORM:  if (r_mag[15]) w_next_state = S_ROUND;
            S_ROUND: w_next_state = S_WR_LO;
            S_WR_LO: w_next_state = S_WR_HI;
            S_WR_HI: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        done      = 1'b0;
        mem_addr  = 8'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 8'd0;
        case (r_state)
            S_RD_LO: begin
                mem_addr = IN_ADDR;
                mem_rd   = 1'b1;
            end
            S_RD_HI: begin
                mem_addr = w_in_addr_hi;
                mem_rd   = 1'b1;
            end
            S_WR_LO: begin
                mem_addr  = OUT_ADDR;
                mem_wdata = r_result[7:0];
                mem_wr    = 1'b1;
            end
            S_WR_HI: begin
                mem_addr  = w_out_addr_hi;
                mem_wdata = r_result[15:8];
                mem_wr    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, magnitude, normalisation and rounding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= 16'd0;
            r_sign   <= 1'b0;
            r_mag    <= 16'd0;
            r_exp    <= 5'd0;
            r_result <= 16'd0;
        end else begin
            case (r_state)
                S_RD_LO: r_x[7:0]  <= mem_rdata;
                S_RD_HI: r_x[15:8] <= mem_rdata;
                S_PREP: begin
                    r_sign <= r_x[15];
                    r_mag  <= r_x[15] ? (~r_x + 16'd1) : r_x;
                    r_exp  <= c_EXP_TOP;
                    if (r_x == 16'd0) r_result <= 16'd0;
                end
                S_NORM: begin
                    if (!r_mag[15]) begin
                        r_mag <= {r_mag[14:0], 1'b0};
                        r_exp <= r_exp - 5'd1;
                    end
                end
                S_ROUND: r_result <= {r_sign, w_rounded};
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int2flt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_int2flt_seq
// Brief    : Self-checking bench for int2flt_seq with a behavioural memory and
//            an arithmetic half-float reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int2flt_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    int cyc        = 0;
    int wr_cnt     = 0;
    int done_cnt   = 0;
    int excl_viol  = 0;
    int checks     = 0;
    int errors     = 0;
    int t0         = 0;
    int t_done     = 0;

    int2flt_seq #(.IN_ADDR(8'd0), .OUT_ADDR(8'd2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_rd && mem_wr) excl_viol <= excl_viol + 1;
    end

    // Reference: exact arithmetic with round-half-to-even on the quotient.
    function automatic logic [15:0] ref_half(input logic [15:0] x);
        int v, m, e, d, q, r, h;
        logic s;
        v = int'($signed(x));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 16'h0000;
        e = 15;
        while (m < (1 << e)) e--;
        if (e > 10) begin
            d = e - 10;
            q = m >> d;
            r = m - (q << d);
            h = 1 << (d - 1);
            if (r > h || (r == h && (q % 2) == 1)) q++;
        end else begin
            q = m << (10 - e);
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        return {s, 5'(e + 15), 10'(q - 1024)};
    endfunction

    // Busy cycles between leaving IDLE and the done cycle.
    function automatic int ref_lat(input logic [15:0] x);
        int v, m, e;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        if (m == 0) return 5;
        e = 15;
        while (m < (1 << e)) e--;
        return 7 + (15 - e);
    endfunction

    task automatic check(input string tag, input int obs, input int want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                found  = 1'b1;
                t_done = cyc;
                break;
            end
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic convert(input logic [15:0] x, input logic [15:0] want, input string tag);
        bit found;
        int w0;
        poke(8'd0, x[7:0]);
        poke(8'd1, x[15:8]);
        w0 = wr_cnt;
        pulse_start();
        wait_done(tag, found);
        if (found) begin
            check({tag, "_lat"}, t_done - t0 - 1, ref_lat(x));
            @(negedge clk);
            check({tag, "_done_pulse"}, int'(done), 0);
            check({tag, "_result"}, int'({mem[3], mem[2]}), int'(want));
            check({tag, "_writes"}, wr_cnt - w0, 2);
        end
    endtask

    logic [15:0] d_in  [8] = '{16'h0001, 16'h7FFF, 16'h0803, 16'h0801,
                               16'h8000, 16'hFFFF, 16'hFF9C, 16'h0000};
    logic [15:0] d_out [8] = '{16'h3C00, 16'h7800, 16'h6802, 16'h6800,
                               16'hF800, 16'hBC00, 16'hD640, 16'h0000};

    initial begin
        bit found;
        int d0, w0;
        logic [15:0] x;

        reset = 1'b1;
        start = 1'b0;
        tb_we = 1'b0;
        tb_addr = 8'd0;
        tb_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_done",  int'(done),      0);
        check("rst_rd",    int'(mem_rd),    0);
        check("rst_wr",    int'(mem_wr),    0);
        check("rst_addr",  int'(mem_addr),  0);
        check("rst_wdata", int'(mem_wdata), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            convert(d_in[i], d_out[i], $sformatf("dir%0d", i));
            check($sformatf("dir%0d_model", i), int'(ref_half(d_in[i])), int'(d_out[i]));
        end

        // Second falling edge of start while normalising must be dropped.
        poke(8'd0, 8'h01);
        poke(8'd1, 8'h00);
        d0 = done_cnt;
        w0 = wr_cnt;
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_done("ign", found);
        repeat (40) @(negedge clk);
        check("ign_done_cnt", done_cnt - d0, 1);
        check("ign_writes",   wr_cnt - w0,   2);
        check("ign_result",   int'({mem[3], mem[2]}), 16'h3C00);
        convert(16'hFF9C, 16'hD640, "after_ign");

        // Async reset while normalising aborts with the old result left in place.
        poke(8'd2, 8'hA5);
        poke(8'd3, 8'h5A);
        poke(8'd0, 8'h01);
        poke(8'd1, 8'h00);
        d0 = done_cnt;
        w0 = wr_cnt;
        pulse_start();
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_done", int'(done),   0);
        check("abort_wr",   int'(mem_wr), 0);
        check("abort_rd",   int'(mem_rd), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_writes", wr_cnt - w0, 0);
        check("abort_dones",  done_cnt - d0, 0);
        check("abort_mem",    int'({mem[3], mem[2]}), 16'h5AA5);
        convert(16'h0001, 16'h3C00, "post_reset");

        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom);
            convert(x, ref_half(x), $sformatf("rnd%0d_%h", i, x));
        end

        repeat (2) @(negedge clk);
        check("rd_wr_exclusive", excl_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
